cache_exerciser: RTL and testbench
==================================

# cache_exerciser

Self-checking traffic initiator for the front side of `Cache`: drives `enable`/`address`/`write_enable`/`data_in` and consumes `data_out`/`data_out_ready`/`busy`. On `start` it writes a pseudo-random word pattern over an address window, overwrites the lower half-word of every odd word, then reads everything back and compares. It reports pass/fail, error count, first failing address and timeouts. It sits where the CPU would, for on-board PSRAM/cache bring-up and regression benches.

## Interface
- `StartAddress`, default 0: byte address of the first word; must be 4-byte aligned.
- `WordCount`, default 32: number of 32-bit words exercised, ≥1; the window is `StartAddress` .. `StartAddress+4*WordCount-4`.
- `Seed`, default 32'h1234_5678: LFSR seed; 0 is replaced by 1.
- `TimeoutCycles`, default 4096: maximum wait cycles per transaction.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: 1-cycle pulse begins a run; ignored while `running`.
- `enable` out 1: cache enable.
- `address` out 32: byte address to cache.
- `write_enable` out 4: byte-lane write strobes, 0 for read.
- `data_in` out 32: write data to cache.
- `data_out` in 32: read data from cache.
- `data_out_ready` in 1: read data valid.
- `busy` in 1: cache busy.
- `running` out 1: run in progress.
- `done` out 1: run finished; sticky until next `start`.
- `pass` out 1: valid with `done`; 1 iff error_count==0 and no timeout.
- `timeout` out 1: a transaction exceeded `TimeoutCycles`.
- `error_count` out 16: mismatches, saturating at 16'hFFFF.
- `first_error_address` out 32: address of the first mismatch, else 0.

## Operation
- Pattern: 32-bit Fibonacci LFSR, `next = {v[30:0], v[31]^v[21]^v[1]^v[0]}`. P(i) is the value after i steps from `Seed`, with P(0)=`Seed`. Each phase restarts from `Seed`.
- States: IDLE, WR_ISSUE, WR_WAIT, HW_ISSUE, HW_WAIT, RD_ISSUE, RD_WAIT, DONE.
- IDLE: `enable`=0. On `start`: clear `done`/`pass`/`timeout`/`error_count`/`first_error_address`, set `running`, word index i=0, go to WR_ISSUE.
- Phase 1 (WR_ISSUE/WR_WAIT), word i: issue `write_enable`=4'b1111, `data_in`=P(i).
- Phase 2 (HW_ISSUE/HW_WAIT), odd i only: issue `write_enable`=4'b0011, `data_in`={16'h0, ~P(i)[15:0]}. Even i are skipped without issuing.
- Phase 3 (RD_ISSUE/RD_WAIT), word i: issue a read. Expected value E(i)=P(i) for even i, {P(i)[31:16], ~P(i)[15:0]} for odd i.
- Compare on `data_out_ready`. On mismatch: increment `error_count` (saturating) and latch `first_error_address` if it is the first mismatch.
- After the last word of phase 3: go to DONE, `running`=0, `done`=1, `pass` set per the rule above, then IDLE.
- Timeout: on a timeout, set `timeout`, abort immediately to DONE with `pass`=0. Remaining words are not exercised.

## Timing
- Reset values: `enable` 0, `address` 0, `write_enable` 0, `data_in` 0, `running` 0, `done` 0, `pass` 0, `timeout` 0, `error_count` 0, `first_error_address` 0. Reset mid-run aborts instantly with no further requests.
- `enable` is held 1 from run start to DONE. Inputs are sampled only when `busy`=0.
- *_ISSUE: wait until a cycle with `busy`=0, then drive `address`/`write_enable`/`data_in` for exactly that cycle. The next cycle is *_WAIT.
- Between transactions, `address` and `data_in` hold their last value and `write_enable` returns to 0.
- WR_WAIT/HW_WAIT: complete on the first cycle with `busy`=0. A write hit therefore completes 1 cycle after issue; a write miss completes after the eviction and fill.
- RD_WAIT: complete on the first cycle with `data_out_ready`=1, at the earliest 1 cycle after issue (hit). `data_out` is sampled in that same cycle.
- Back-to-back hits sustain one transaction per 2 cycles (ISSUE + WAIT).
- Wait counter: cleared on each issue and incremented each WAIT cycle. Timeout when it reaches `TimeoutCycles` without completion.
- `done`/`pass` assert the cycle after the last read completes. `start` in that same cycle is accepted, since `running` is already 0.
- Address arithmetic is 32-bit with wrap-around: `address` = `StartAddress + 4*i`.

## Test plan
- Bench setup: Cache(LineIndexBitWidth 1, RamDepthBitWidth 4, RamAddressingMode 3) + BurstRAM(DEPTH_BITWIDTH 4, BURST_COUNT 4).
- Full run: `WordCount`=32, `StartAddress`=0, start pulse -> `done`=1, `pass`=1, `error_count`=0, `timeout`=0. Exactly 32+16+32 = 80 transactions issued.
- Fault injection: force `data_out` bit 0 inverted whenever `address`==40 during phase 3 -> `error_count`=1, `first_error_address`=40, `pass`=0.
- Timeout: `TimeoutCycles`=16, hold `busy`=1 after the first issue -> `timeout`=1 within 17 cycles, `done`=1, `pass`=0, `enable` stays 0 afterwards.
- Boundary: `WordCount`=1, `StartAddress`=124 -> writes P(0) to 124, no half-word write, reads back 124, `pass`=1. A `start` during the run is ignored; a second `start` after `done` reruns and passes again.
- Reset mid-run: drop `rst_n` during phase 2 -> all outputs at reset values immediately. A new `start` after release completes with `pass`=1.

Source files
------------

// File: rtl/cache_exerciser_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_exerciser_if
// Brief    : Front-side cache request/response bundle (CPU side of Cache).
// Revision : 1.0
// ============================================================================
interface cache_exerciser_if;
  logic        enable;
  logic [31:0] address;
  logic [3:0]  write_enable;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;

  modport master (
    output enable, address, write_enable, data_in,
    input  data_out, data_out_ready, busy
  );

  modport slave (
    input  enable, address, write_enable, data_in,
    output data_out, data_out_ready, busy
  );
endinterface
`default_nettype wire

// File: rtl/cache_exerciser.sv
`default_nettype none
// ============================================================================
// Module   : cache_exerciser
// Brief    : Write / half-word overwrite / read-back traffic initiator for Cache.
// Revision : 1.0
// ============================================================================
module cache_exerciser #(
  parameter logic [31:0] StartAddress  = 32'h0,
  parameter int unsigned WordCount     = 32,
  parameter logic [31:0] Seed          = 32'h1234_5678,
  parameter int unsigned TimeoutCycles = 4096
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         start,
  cache_exerciser_if.master cache,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       error_count,
  output logic [31:0]       first_error_address
);

  localparam logic [31:0] c_seed         = (Seed == 32'h0) ? 32'h1 : Seed;
  localparam logic [31:0] c_last_idx     = 32'(WordCount - 1);
  localparam logic [31:0] c_word_count   = 32'(WordCount);
  localparam logic [31:0] c_timeout_last = 32'(TimeoutCycles - 1);

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_wr_issue = 3'd1;
  localparam logic [2:0] c_st_wr_wait  = 3'd2;
  localparam logic [2:0] c_st_hw_issue = 3'd3;
  localparam logic [2:0] c_st_hw_wait  = 3'd4;
  localparam logic [2:0] c_st_rd_issue = 3'd5;
  localparam logic [2:0] c_st_rd_wait  = 3'd6;
  localparam logic [2:0] c_st_done     = 3'd7;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  logic [2:0]  r_state;
  logic [31:0] r_idx;
  logic [31:0] r_lfsr;
  logic [31:0] r_wait_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_running;
  logic        r_done;
  logic        r_pass;
  logic        r_timeout;
  logic [15:0] r_err;
  logic [31:0] r_first;

  logic        w_complete;
  logic [2:0]  w_nxt_state;
  logic [31:0] w_nxt_idx;
  logic [31:0] w_nxt_lfsr;
  logic [31:0] w_nxt_addr;
  logic [31:0] w_nxt_data;
  logic [31:0] w_expect;
  logic        w_mismatch;
  logic [15:0] w_err_nxt;

  // Successor of each WAIT state; the half-word pass walks odd words only.
  always_comb begin
    w_complete  = 1'b0;
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_lfsr  = r_lfsr;
    case (r_state)
      c_st_wr_wait: begin
        w_complete = !cache.busy;
        if (r_idx != c_last_idx) begin
          w_nxt_state = c_st_wr_issue;
          w_nxt_idx   = r_idx + 32'd1;
          w_nxt_lfsr  = lfsr_next(r_lfsr);
        end else if (c_word_count > 32'd1) begin
          w_nxt_state = c_st_hw_issue;
          w_nxt_idx   = 32'd1;
          w_nxt_lfsr  = lfsr_next(c_seed);
        end else begin
          w_nxt_state = c_st_rd_issue;
          w_nxt_idx   = 32'd0;
          w_nxt_lfsr  = c_seed;
        end
      end
      c_st_hw_wait: begin
        w_complete = !cache.busy;
        if (r_idx + 32'd2 < c_word_count) begin
          w_nxt_state = c_st_hw_issue;
          w_nxt_idx   = r_idx + 32'd2;
          w_nxt_lfsr  = lfsr_next(lfsr_next(r_lfsr));
        end else begin
          w_nxt_state = c_st_rd_issue;
          w_nxt_idx   = 32'd0;
          w_nxt_lfsr  = c_seed;
        end
      end
      c_st_rd_wait: begin
        w_complete = cache.data_out_ready;
        if (r_idx != c_last_idx) begin
          w_nxt_state = c_st_rd_issue;
          w_nxt_idx   = r_idx + 32'd1;
          w_nxt_lfsr  = lfsr_next(r_lfsr);
        end else begin
          w_nxt_state = c_st_done;
        end
      end
      default: ;
    endcase
  end

  assign w_nxt_addr = StartAddress + (w_nxt_idx << 2);
  assign w_nxt_data = (w_nxt_state == c_st_hw_issue) ? {16'h0, ~w_nxt_lfsr[15:0]} : w_nxt_lfsr;
  assign w_expect   = r_idx[0] ? {r_lfsr[31:16], ~r_lfsr[15:0]} : r_lfsr;
  assign w_mismatch = (r_state == c_st_rd_wait) && cache.data_out_ready
                      && (cache.data_out != w_expect);
  assign w_err_nxt  = (w_mismatch && (r_err != 16'hFFFF)) ? r_err + 16'd1 : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_idx      <= 32'h0;
      r_lfsr     <= 32'h0;
      r_wait_cnt <= 32'h0;
      r_addr     <= 32'h0;
      r_data     <= 32'h0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= 16'h0;
      r_first    <= 32'h0;
    end else begin
      case (r_state)
        c_st_idle, c_st_done: begin
          r_state <= c_st_idle;
          if (start) begin
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_err     <= 16'h0;
            r_first   <= 32'h0;
            r_running <= 1'b1;
            r_idx     <= 32'h0;
            r_lfsr    <= c_seed;
            r_addr    <= StartAddress;
            r_data    <= c_seed;
            r_state   <= c_st_wr_issue;
          end
        end
        c_st_wr_issue, c_st_hw_issue, c_st_rd_issue: begin
          if (!cache.busy) begin
            r_wait_cnt <= 32'h0;
            case (r_state)
              c_st_wr_issue: r_state <= c_st_wr_wait;
              c_st_hw_issue: r_state <= c_st_hw_wait;
              default:       r_state <= c_st_rd_wait;
            endcase
          end
        end
        c_st_wr_wait, c_st_hw_wait, c_st_rd_wait: begin
          if (w_complete) begin
            r_err <= w_err_nxt;
            if (w_mismatch && (r_err == 16'h0)) begin
              r_first <= r_addr;
            end
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_lfsr  <= w_nxt_lfsr;
            r_addr  <= w_nxt_addr;
            if ((w_nxt_state == c_st_wr_issue) || (w_nxt_state == c_st_hw_issue)) begin
              r_data <= w_nxt_data;
            end
            if (w_nxt_state == c_st_done) begin
              r_running <= 1'b0;
              r_done    <= 1'b1;
              r_pass    <= (w_err_nxt == 16'h0);
            end
          end else if (r_wait_cnt == c_timeout_last) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
            r_running <= 1'b0;
            r_state   <= c_st_done;
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Strobes are qualified by busy so a request is presented only in its accept cycle.
  always_comb begin
    cache.write_enable = 4'b0000;
    if (!cache.busy) begin
      if (r_state == c_st_wr_issue) begin
        cache.write_enable = 4'b1111;
      end else if (r_state == c_st_hw_issue) begin
        cache.write_enable = 4'b0011;
      end
    end
  end

  assign cache.enable        = r_running;
  assign cache.address       = r_addr;
  assign cache.data_in       = r_data;
  assign running             = r_running;
  assign done                = r_done;
  assign pass                = r_pass;
  assign timeout             = r_timeout;
  assign error_count         = r_err;
  assign first_error_address = r_first;

endmodule
`default_nettype wire

// File: tb/tb_cache_exerciser.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_exerciser
// Brief    : Randomised-latency cache model with write and result scoreboards.
// Revision : 1.0
// ============================================================================
module tb_cache_exerciser;
  localparam logic [31:0] START = 32'hFFFF_FFF8;
  localparam int          WORDS = 5;
  localparam logic [31:0] SEED  = 32'h0;
  localparam int          TMO   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        running, done, pass, timeout;
  logic [15:0] error_count;
  logic [31:0] first_error_address;

  cache_exerciser_if bus();

  cache_exerciser #(
    .StartAddress(START), .WordCount(WORDS), .Seed(SEED), .TimeoutCycles(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cache(bus),
    .running(running), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .first_error_address(first_error_address)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] data; } wr_t;
  typedef struct { logic ok; logic tmo; logic [15:0] err; logic [31:0] first; } res_t;
  wr_t         wr_q[$];
  res_t        res_q[$];
  logic [31:0] mem [0:7];
  logic [31:0] fault_addrs[$];
  bit          stall_arm = 1'b0;
  bit          stall = 1'b0;
  int          stall_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference pattern straight from the LFSR definition, restarted per word.
  function automatic logic [31:0] pat(input int i);
    logic [31:0] v = (SEED == 32'h0) ? 32'h1 : SEED;
    for (int k = 0; k < i; k++) v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    return v;
  endfunction

  function automatic logic [31:0] waddr(input int i);
    return START + 32'(4 * i);
  endfunction

  function automatic logic [31:0] expv(input int i);
    logic [31:0] p = pat(i);
    return (i % 2 == 1) ? {p[31:16], ~p[15:0]} : p;
  endfunction

  function automatic logic [2:0] widx(input logic [31:0] a);
    logic [31:0] d = a - START;
    return d[4:2];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] d);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (we[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [31:0] v = mem[widx(a)];
    foreach (fault_addrs[k]) if (fault_addrs[k] == a) v[0] = ~v[0];
    return v;
  endfunction

  // Cache model: accepts a request in any enabled cycle with busy low, random latency 0..3.
  logic        m_pend = 1'b0;
  logic [31:0] m_addr = 32'h0;
  int          m_cnt = 0;
  int          m_lat = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy           <= 1'b0;
      bus.data_out_ready <= 1'b0;
      bus.data_out       <= 32'h0;
      m_pend             <= 1'b0;
      m_cnt              <= 0;
    end else begin
      bus.data_out_ready <= 1'b0;
      m_lat              <= int'($urandom_range(0, 3));
      if (stall) begin
        bus.busy <= 1'b1;
        m_cnt    <= 0;
        m_pend   <= 1'b0;
      end else if (bus.busy) begin
        if (m_cnt == 0) begin
          bus.busy <= 1'b0;
          if (m_pend) begin
            bus.data_out_ready <= 1'b1;
            bus.data_out       <= rd(m_addr);
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (bus.enable) begin
        if (bus.write_enable != 4'h0)
          mem[widx(bus.address)] <= merge(mem[widx(bus.address)], bus.write_enable, bus.data_in);
        if (m_lat != 0) begin
          bus.busy <= 1'b1;
          m_cnt    <= m_lat - 1;
          m_pend   <= (bus.write_enable == 4'h0);
          m_addr   <= bus.address;
        end else if (bus.write_enable == 4'h0) begin
          bus.data_out_ready <= 1'b1;
          bus.data_out       <= rd(bus.address);
        end
      end
    end
  end

  // Write monitor
  wr_t mon_w;
  always @(negedge clk) begin
    if (rst_n && bus.enable && !bus.busy && bus.write_enable != 4'h0) begin
      if (stall_arm) begin
        stall     = 1'b1;
        stall_arm = 1'b0;
        stall_cyc = cyc;
      end
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h we %0h, want no write", bus.address,
                 bus.write_enable);
      end else begin
        mon_w = wr_q.pop_front();
        chk("wr_addr", bus.address, mon_w.addr);
        chk("wr_we", 32'(bus.write_enable), 32'(mon_w.we));
        chk("wr_data", bus.data_in, mon_w.data);
      end
    end
  end

  // Result monitor
  res_t mon_r;
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (res_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1, want 0");
      end else begin
        mon_r = res_q.pop_front();
        chk("res_pass", 32'(pass), 32'(mon_r.ok));
        chk("res_timeout", 32'(timeout), 32'(mon_r.tmo));
        chk("res_err", 32'(error_count), 32'(mon_r.err));
        chk("res_first", first_error_address, mon_r.first);
        chk("res_running", 32'(running), 32'h0);
      end
    end
    done_q = done;
  end

  task automatic push_writes();
    logic [31:0] p;
    for (int i = 0; i < WORDS; i++) wr_q.push_back('{waddr(i), 4'b1111, pat(i)});
    for (int i = 1; i < WORDS; i += 2) begin
      p = pat(i);
      wr_q.push_back('{waddr(i), 4'b0011, {16'h0, ~p[15:0]}});
    end
  endtask

  task automatic push_res(input logic ok, input logic tmo, input logic [15:0] err,
                          input logic [31:0] first);
    res_q.push_back('{ok, tmo, err, first});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    chk(nm, 32'(done), 32'h1);
  endtask

  task automatic check_mem();
    for (int i = 0; i < WORDS; i++) chk("mem_word", mem[i], expv(i));
  endtask

  task automatic check_reset_vals();
    chk("rst_enable", 32'(bus.enable), 32'h0);
    chk("rst_address", bus.address, 32'h0);
    chk("rst_write_enable", 32'(bus.write_enable), 32'h0);
    chk("rst_data_in", bus.data_in, 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_pass", 32'(pass), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_error_count", 32'(error_count), 32'h0);
    chk("rst_first_error", first_error_address, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int j, j1, j2, lat, n;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // Clean run with a stray start mid-run
    push_writes();
    push_res(1'b1, 1'b0, 16'h0, 32'h0);
    pulse_start();
    repeat (6) @(negedge clk);
    pulse_start();
    wait_done(2000, "clean_done");
    chk("clean_wr_left", 32'(wr_q.size()), 32'h0);
    check_mem();
    repeat (4) @(negedge clk);
    chk("sticky_done", 32'(done), 32'h1);
    chk("sticky_pass", 32'(pass), 32'h1);
    chk("idle_enable", 32'(bus.enable), 32'h0);

    // Single fault
    j = int'($urandom_range(0, WORDS - 1));
    fault_addrs = '{waddr(j)};
    push_writes();
    push_res(1'b0, 1'b0, 16'd1, waddr(j));
    @(negedge clk);
    pulse_start();
    wait_done(2000, "fault1_done");
    chk("fault1_wr_left", 32'(wr_q.size()), 32'h0);

    // Two faults, started in the DONE cycle of the previous run
    j1 = int'($urandom_range(0, WORDS - 2));
    j2 = int'($urandom_range(j1 + 1, WORDS - 1));
    fault_addrs = '{waddr(j2), waddr(j1)};
    push_writes();
    push_res(1'b0, 1'b0, 16'd2, waddr(j1));
    pulse_start();
    wait_done(2000, "fault2_done");
    chk("fault2_wr_left", 32'(wr_q.size()), 32'h0);
    fault_addrs.delete();

    // Timeout: busy held after the first issue
    wr_q.push_back('{waddr(0), 4'b1111, pat(0)});
    push_res(1'b0, 1'b1, 16'h0, 32'h0);
    stall_arm = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_done(100, "tmo_done");
    lat = cyc - stall_cyc;
    chk("tmo_latency", 32'(lat >= 16 && lat <= 17), 32'h1);
    repeat (3) @(negedge clk);
    chk("tmo_enable", 32'(bus.enable), 32'h0);
    chk("tmo_wr_left", 32'(wr_q.size()), 32'h0);
    stall = 1'b0;
    repeat (3) @(negedge clk);

    // Recovery run, chained straight into a second run
    push_writes();
    push_res(1'b1, 1'b0, 16'h0, 32'h0);
    pulse_start();
    wait_done(2000, "recover_done");
    push_writes();
    push_res(1'b1, 1'b0, 16'h0, 32'h0);
    pulse_start();
    wait_done(2000, "chain_done");
    check_mem();

    // Reset during the half-word phase
    push_writes();
    push_res(1'b1, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    pulse_start();
    n = 0;
    while (!(bus.write_enable == 4'b0011 && !bus.busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("hw_phase_seen", 32'(bus.write_enable), 32'h3);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    wr_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_hold_enable", 32'(bus.enable), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    push_writes();
    push_res(1'b1, 1'b0, 16'h0, 32'h0);
    pulse_start();
    wait_done(2000, "post_rst_done");
    chk("post_rst_pass", 32'(pass), 32'h1);
    check_mem();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
